// File: rtl/multiplier_seq_taint_gen2_if.sv
// Request/response bundle for the tainted sequential multiplier.
// master drives the operands and start; slave is the multiplier itself.
interface multiplier_seq_taint_gen2_if #(
  parameter int unsigned Width = 64
);
  logic               start;
  logic               start_t;
  logic               signed_mode;
  logic               signed_mode_t;
  logic [Width-1:0]   multiplier;
  logic               multiplier_t;
  logic [Width-1:0]   multiplicand;
  logic               multiplicand_t;
  logic               busy;
  logic               busy_t;
  logic [2*Width-1:0] product;
  logic               product_t;
  logic               product_done;
  logic               product_done_t;

  modport master (
    output start, start_t, signed_mode, signed_mode_t,
    output multiplier, multiplier_t, multiplicand, multiplicand_t,
    input  busy, busy_t, product, product_t, product_done, product_done_t
  );

  modport slave (
    input  start, start_t, signed_mode, signed_mode_t,
    input  multiplier, multiplier_t, multiplicand, multiplicand_t,
    output busy, busy_t, product, product_t, product_done, product_done_t
  );
endinterface

// File: rtl/multiplier_seq_taint_gen2.sv
// Sequential shift-add multiplier with 1-bit taint tracking for data and control.
// Retires Step multiplier bits per RUN cycle; optional early exit once the
// remaining multiplier bits are zero (which makes completion timing data-dependent).
// Width must be >= 2 and Step must divide Width.
module multiplier_seq_taint_gen2 #(
  parameter int unsigned Width     = 64,
  parameter int unsigned Step      = 1,
  parameter bit          EarlyExit = 1'b0
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  multiplier_seq_taint_gen2_if.slave bus_io
);

  localparam int unsigned Width2 = 2 * Width;
  localparam int unsigned Iters  = Width / Step;
  localparam int unsigned CntW   = $clog2(Iters + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [Width-1:0]   mplier_q;     // remaining multiplier magnitude bits
  logic [Width2-1:0]  mcand_q;      // multiplicand magnitude, pre-shifted to current weight
  logic [Width2-1:0]  sum_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q;
  logic               data_t_q;     // taint of operand values and mode
  logic               ctl_t_q;      // taint of the start decision
  logic               timing_t_q;   // taint of completion timing
  logic               busy_q;
  logic               done_q;
  logic [Width2-1:0]  product_q;
  logic               product_t_q;

  logic [Width-1:0]   a_mag, b_mag;
  logic [Width2-1:0]  partial, sum_next;
  logic [Width-1:0]   mplier_shift;
  logic [CntW-1:0]    cnt_next;
  logic               run_last;
  logic               neg_next;

  // Operand magnitudes and one RUN step of the shift-add datapath.
  always_comb begin
    a_mag = bus_io.multiplier;
    b_mag = bus_io.multiplicand;
    if (bus_io.signed_mode && bus_io.multiplier[Width-1]) a_mag = -bus_io.multiplier;
    if (bus_io.signed_mode && bus_io.multiplicand[Width-1]) b_mag = -bus_io.multiplicand;
    neg_next     = bus_io.signed_mode &
                   (bus_io.multiplier[Width-1] ^ bus_io.multiplicand[Width-1]);
    partial      = mcand_q * Width2'(mplier_q[Step-1:0]);
    sum_next     = sum_q + partial;
    mplier_shift = mplier_q >> Step;
    cnt_next     = cnt_q - CntW'(1);
    run_last     = (cnt_next == '0) || (EarlyExit && (mplier_shift == '0));
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mplier_q    <= '0;
      mcand_q     <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      data_t_q    <= 1'b0;
      ctl_t_q     <= 1'b0;
      timing_t_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      product_q   <= '0;
      product_t_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Keeping the old product is itself a consequence of start, so it inherits start_t.
          product_t_q <= product_t_q | bus_io.start_t;
          if (bus_io.start) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            mplier_q   <= a_mag;
            mcand_q    <= Width2'(b_mag);
            sum_q      <= '0;
            cnt_q      <= CntW'(Iters);
            neg_q      <= neg_next;
            data_t_q   <= bus_io.multiplier_t | bus_io.multiplicand_t | bus_io.signed_mode_t;
            ctl_t_q    <= bus_io.start_t;
            timing_t_q <= EarlyExit ? (bus_io.start_t | bus_io.multiplier_t |
                                       bus_io.signed_mode_t)
                                    : bus_io.start_t;
          end
        end
        StRun: begin
          sum_q    <= sum_next;
          mplier_q <= mplier_shift;
          mcand_q  <= mcand_q << Step;
          cnt_q    <= cnt_next;
          if (run_last) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            product_q   <= neg_q ? -sum_next : sum_next;
            product_t_q <= data_t_q | ctl_t_q;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy           = busy_q;
  assign bus_io.product        = product_q;
  assign bus_io.product_t      = product_t_q;
  assign bus_io.product_done   = done_q;
  // In IDLE the only thing deciding whether busy/done will rise is start itself.
  assign bus_io.busy_t         = (state_q == StIdle) ? bus_io.start_t : timing_t_q;
  assign bus_io.product_done_t = (state_q == StIdle) ? bus_io.start_t : timing_t_q;

endmodule

// File: tb/tb_multiplier_seq_taint_gen2.sv
// Directed bench: three instances (Step=1, Step=2, Step=1 with early exit), Width=8.
module tb_multiplier_seq_taint_gen2;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  multiplier_seq_taint_gen2_if #(.Width(8)) bus0 ();
  multiplier_seq_taint_gen2_if #(.Width(8)) bus1 ();
  multiplier_seq_taint_gen2_if #(.Width(8)) bus2 ();

  multiplier_seq_taint_gen2 #(.Width(8), .Step(1), .EarlyExit(1'b0)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus0)
  );
  multiplier_seq_taint_gen2 #(.Width(8), .Step(2), .EarlyExit(1'b0)) u_s2 (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus1)
  );
  multiplier_seq_taint_gen2 #(.Width(8), .Step(1), .EarlyExit(1'b1)) u_ee (
    .clk_i(clk), .rst_ni(rst_n), .bus_io(bus2)
  );

  logic        busy_w   [3];
  logic        busy_t_w [3];
  logic        done_w   [3];
  logic        done_t_w [3];
  logic [15:0] prod_w   [3];
  logic        prod_t_w [3];

  assign busy_w[0] = bus0.busy;   assign busy_t_w[0] = bus0.busy_t;
  assign done_w[0] = bus0.product_done; assign done_t_w[0] = bus0.product_done_t;
  assign prod_w[0] = bus0.product; assign prod_t_w[0] = bus0.product_t;
  assign busy_w[1] = bus1.busy;   assign busy_t_w[1] = bus1.busy_t;
  assign done_w[1] = bus1.product_done; assign done_t_w[1] = bus1.product_done_t;
  assign prod_w[1] = bus1.product; assign prod_t_w[1] = bus1.product_t;
  assign busy_w[2] = bus2.busy;   assign busy_t_w[2] = bus2.busy_t;
  assign done_w[2] = bus2.product_done; assign done_t_w[2] = bus2.product_done_t;
  assign prod_w[2] = bus2.product; assign prod_t_w[2] = bus2.product_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int s, input logic st, input logic st_t, input logic sm,
                       input logic sm_t, input logic [7:0] a, input logic a_t,
                       input logic [7:0] b, input logic b_t);
    case (s)
      0: begin
        bus0.start = st; bus0.start_t = st_t; bus0.signed_mode = sm; bus0.signed_mode_t = sm_t;
        bus0.multiplier = a; bus0.multiplier_t = a_t;
        bus0.multiplicand = b; bus0.multiplicand_t = b_t;
      end
      1: begin
        bus1.start = st; bus1.start_t = st_t; bus1.signed_mode = sm; bus1.signed_mode_t = sm_t;
        bus1.multiplier = a; bus1.multiplier_t = a_t;
        bus1.multiplicand = b; bus1.multiplicand_t = b_t;
      end
      default: begin
        bus2.start = st; bus2.start_t = st_t; bus2.signed_mode = sm; bus2.signed_mode_t = sm_t;
        bus2.multiplier = a; bus2.multiplier_t = a_t;
        bus2.multiplicand = b; bus2.multiplicand_t = b_t;
      end
    endcase
  endtask

  // Issues one operation and waits (bounded) for productDone. lat counts the start
  // cycle as cycle 1; lat=0 means no completion was seen. Optionally pulses start mid-RUN.
  task automatic op(input int s, input logic sm, input logic sm_t, input logic st_t,
                    input logic [7:0] a, input logic a_t, input logic [7:0] b,
                    input logic b_t, input bit inject, output int lat,
                    output logic [15:0] p, output logic pt, output logic dt,
                    output logic bt);
    bit got;
    @(negedge clk);
    drive(s, 1'b1, st_t, sm, sm_t, a, a_t, b, b_t);
    @(negedge clk);
    drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    lat = 0; got = 1'b0; p = '0; pt = 1'b0; dt = 1'b0; bt = 1'b0;
    for (int m = 0; m < 40 && !got; m++) begin
      if (done_w[s] === 1'b1) begin
        got = 1'b1;
        lat = m + 1;
        p   = prod_w[s];
        pt  = prod_t_w[s];
        dt  = done_t_w[s];
        bt  = busy_t_w[s];
      end else begin
        if (inject && m == 1) drive(s, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 1'b1);
        if (inject && m == 2) drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #12;
    for (int s = 0; s < 3; s++) begin
      checks++; if (busy_w[s] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", s, busy_w[s]); end
      checks++; if (done_w[s] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", s, done_w[s]); end
      checks++; if (prod_w[s] !== 16'h0) begin errors++; $display("FAIL reset_product[%0d] got %h want 0000", s, prod_w[s]); end
      checks++; if (prod_t_w[s] !== 1'b0) begin errors++; $display("FAIL reset_product_t[%0d] got %b want 0", s, prod_t_w[s]); end
      checks++; if (busy_t_w[s] !== 1'b0) begin errors++; $display("FAIL reset_busy_t[%0d] got %b want 0", s, busy_t_w[s]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_step1;
    int lat; logic [15:0] p; logic pt, dt, bt;
    op(0, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 8'd255, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL u255x255 got %h want fe01", p); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL u255x255_latency got %0d want 9", lat); end
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL u255x255_product_t got %b want 0", pt); end
    checks++; if (dt !== 1'b0) begin errors++; $display("FAIL u255x255_done_t got %b want 0", dt); end
  endtask

  task automatic test_signed;
    int lat; logic [15:0] p; logic pt, dt, bt;
    op(0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'h4000) begin errors++; $display("FAIL s_m128xm128 got %h want 4000", p); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL s_m128_latency got %0d want 9", lat); end
    op(0, 1'b1, 1'b0, 1'b0, 8'hFD, 1'b0, 8'd5, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'hFFF1) begin errors++; $display("FAIL s_m3x5 got %h want fff1", p); end
    op(0, 1'b0, 1'b0, 1'b0, 8'hFD, 1'b0, 8'd5, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'h04F1) begin errors++; $display("FAIL u253x5 got %h want 04f1", p); end
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL u253x5_product_t got %b want 0", pt); end
  endtask

  task automatic test_step2;
    int lat; int extra; logic [15:0] p; logic pt, dt, bt;
    op(1, 1'b0, 1'b0, 1'b0, 8'd200, 1'b0, 8'd150, 1'b0, 1'b1, lat, p, pt, dt, bt);
    checks++; if (p !== 16'h7530) begin errors++; $display("FAIL s2_200x150 got %h want 7530", p); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL s2_latency got %0d want 5", lat); end
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL s2_product_t got %b want 0", pt); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_w[1] === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL s2_ignored_start extra dones got %0d want 0", extra); end
    checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL s2_busy_after got %b want 0", busy_w[1]); end
  endtask

  task automatic test_early_exit;
    int lat; logic [15:0] p; logic pt, dt, bt;
    op(2, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 8'd7, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'd21) begin errors++; $display("FAIL ee_3x7 got %h want 0015", p); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ee_3x7_latency got %0d want 3", lat); end
    checks++; if (dt !== 1'b1) begin errors++; $display("FAIL ee_mt_done_t got %b want 1", dt); end
    checks++; if (bt !== 1'b1) begin errors++; $display("FAIL ee_mt_busy_t got %b want 1", bt); end
    checks++; if (pt !== 1'b1) begin errors++; $display("FAIL ee_mt_product_t got %b want 1", pt); end
    op(2, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd7, 1'b1, 1'b0, lat, p, pt, dt, bt);
    checks++; if (dt !== 1'b0) begin errors++; $display("FAIL ee_bt_done_t got %b want 0", dt); end
    checks++; if (bt !== 1'b0) begin errors++; $display("FAIL ee_bt_busy_t got %b want 0", bt); end
    checks++; if (pt !== 1'b1) begin errors++; $display("FAIL ee_bt_product_t got %b want 1", pt); end
    op(2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd9, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ee_zero_latency got %0d want 2", lat); end
    checks++; if (p !== 16'd0) begin errors++; $display("FAIL ee_zero got %h want 0000", p); end
    op(2, 1'b1, 1'b0, 1'b0, 8'hFD, 1'b0, 8'd7, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'hFFEB) begin errors++; $display("FAIL ee_m3x7 got %h want ffeb", p); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ee_m3x7_latency got %0d want 3", lat); end
  endtask

  task automatic test_taint_idle;
    int lat; logic [15:0] p; logic pt, dt, bt;
    @(negedge clk);
    checks++; if (prod_t_w[0] !== 1'b0) begin errors++; $display("FAIL idle_pre_product_t got %b want 0", prod_t_w[0]); end
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (busy_t_w[0] !== 1'b1) begin errors++; $display("FAIL idle_busy_t got %b want 1", busy_t_w[0]); end
    checks++; if (done_t_w[0] !== 1'b1) begin errors++; $display("FAIL idle_done_t got %b want 1", done_t_w[0]); end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    #1;
    checks++; if (prod_t_w[0] !== 1'b1) begin errors++; $display("FAIL idle_product_t_set got %b want 1", prod_t_w[0]); end
    checks++; if (busy_t_w[0] !== 1'b0) begin errors++; $display("FAIL idle_busy_t_clr got %b want 0", busy_t_w[0]); end
    repeat (3) @(negedge clk);
    checks++; if (prod_t_w[0] !== 1'b1) begin errors++; $display("FAIL idle_product_t_hold got %b want 1", prod_t_w[0]); end
    op(0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (pt !== 1'b0) begin errors++; $display("FAIL idle_product_t_clear got %b want 0", pt); end
    checks++; if (p !== 16'd6) begin errors++; $display("FAIL idle_2x3 got %h want 0006", p); end
  endtask

  task automatic test_back_to_back;
    int lat; bit got; logic [15:0] p; logic pt, dt, bt;
    op(1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd3, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'd6) begin errors++; $display("FAIL b2b_first got %h want 0006", p); end
    // Currently in DONE: a start here must be ignored, then accepted one cycle later.
    drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 8'd5, 1'b0);
    @(negedge clk);
    checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore busy got %b want 0", busy_w[1]); end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checks++; if (busy_w[1] !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", busy_w[1]); end
    got = 1'b0;
    for (int m = 0; m < 20 && !got; m++) begin
      if (done_w[1] === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!got || prod_w[1] !== 16'd20) begin errors++; $display("FAIL b2b_second got %h done=%b want 0014", prod_w[1], got); end
  endtask

  task automatic test_reset_mid_run;
    int lat; int extra; logic [15:0] p; logic pt, dt, bt;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, 8'd255, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (busy_t_w[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_busy_t got %b want 1", busy_t_w[0]); end
    checks++; if (busy_w[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got %b want 1", busy_w[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy_w[0]); end
    checks++; if (busy_t_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_busy_t got %b want 0", busy_t_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done_w[0]); end
    checks++; if (done_t_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_done_t got %b want 0", done_t_w[0]); end
    checks++; if (prod_w[0] !== 16'd0) begin errors++; $display("FAIL mid_rst_product got %h want 0000", prod_w[0]); end
    checks++; if (prod_t_w[0] !== 1'b0) begin errors++; $display("FAIL mid_rst_product_t got %b want 0", prod_t_w[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL mid_rst_stray_done got %0d want 0", extra); end
    op(0, 1'b0, 1'b0, 1'b0, 8'd6, 1'b0, 8'd7, 1'b0, 1'b0, lat, p, pt, dt, bt);
    checks++; if (p !== 16'd42) begin errors++; $display("FAIL mid_rst_6x7 got %h want 002a", p); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL mid_rst_6x7_latency got %0d want 9", lat); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_unsigned_step1();
    test_signed();
    test_step2();
    test_early_exit();
    test_taint_idle();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_seq_taint_gen2.md
# multiplier_seq_taint_gen2

Sequential shift-add multiplier with 1-bit-per-signal taint tracking. Generalises the first-generation tainted multiplier with signed/unsigned mode, configurable bits-retired-per-cycle, optional early termination, and a busy indication. Taint is propagated separately for data and control, so timing leaks from early exit are flagged. Sits in the taint-tracking datapath library as a drop-in arithmetic unit for information-flow experiments.

## Interface
- WIDTH, 64: operand width. Must be ≥ 2.
- STEP, 1: multiplier bits retired per RUN cycle. Must divide WIDTH.
- EARLY_EXIT, 0: 1 = leave RUN as soon as the remaining multiplier bits are all zero.

- clk  in  1  clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- start_t  in  1  taint of start.
- signed_mode  in  1  1 = two's-complement operands; sampled with start.
- signed_mode_t  in  1  taint of signed_mode.
- multiplier  in  WIDTH  operand A.
- multiplier_t  in  1  taint of multiplier.
- multiplicand  in  WIDTH  operand B.
- multiplicand_t  in  1  taint of multiplicand.
- busy  out  1  high in RUN and DONE.
- busy_t  out  1  taint of busy.
- product  out  2*WIDTH  result; held until the next completion.
- product_t  out  1  taint of product.
- productDone  out  1  one-cycle completion pulse.
- productDone_t  out  1  taint of productDone.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1:
  - Latch |multiplier| and |multiplicand|. Magnitudes are used when signed_mode=1; raw values otherwise.
  - Latch neg = signed_mode & (msbA ^ msbB).
  - Clear the 2*WIDTH running sum and load the iteration counter with WIDTH/STEP.
- RUN, each cycle:
  - sum += (multiplicand magnitude × low STEP bits of the multiplier register) << (STEP × iteration).
  - Multiplier register shifts right by STEP; counter decrements.
  - Exit to DONE when the counter reaches 0.
  - If EARLY_EXIT=1, also exit when the shifted multiplier register is 0. At least one RUN cycle always occurs.
- DONE:
  - product ← neg ? −sum : sum.
  - productDone=1 for exactly this cycle; next state is IDLE.
- start in RUN or DONE is ignored; there is no queueing.
- Arithmetic: magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) and fits WIDTH unsigned bits. The 2*WIDTH product never overflows in either mode.
- Taint, latched on acceptance:
  - d_t = multiplier_t | multiplicand_t | signed_mode_t.
  - c_t = start_t.
- Taint outputs:
  - product_t at DONE = d_t | c_t.
  - In IDLE, product_t ← product_t | start_t every cycle, because whether product is retained depends on start. Only a completion or reset clears it.
  - productDone_t and busy_t = c_t when EARLY_EXIT=0.
  - With EARLY_EXIT=1 they are c_t | multiplier_t | signed_mode_t, since completion timing depends on the multiplier value.
  - In IDLE, busy_t = productDone_t = start_t.
- Reset (any time, including mid-RUN):
  - State IDLE; product=0; all taints 0; busy=0; productDone=0.
  - An in-flight operation is discarded.

## Timing
- start sampled at edge E0 in IDLE → busy=1 after E0.
- RUN occupies N = WIDTH/STEP cycles, or fewer with EARLY_EXIT.
- DONE follows: productDone=1 and product valid in the cycle after edge E0+N; latency N+1 cycles. busy drops after the following edge.
- The earliest next accept is start sampled in the cycle after DONE; throughput is one operation per N+2 cycles.
- With EARLY_EXIT, RUN length = max(1, index of the highest set multiplier-magnitude STEP-group + 1). A zero multiplier gives latency 2.
- product and product_t change only at the edge entering DONE, at reset, or (product_t only) via IDLE start_t accumulation.

## Test plan
Bench uses WIDTH=8.
- Unsigned, STEP=1, EARLY_EXIT=0: 255×255 → product=0xFE01; productDone 9 cycles after start; product_t=productDone_t=0.
- Signed, STEP=1: −128×−128 → 0x4000. Signed −3×5 → 0xFFF1. Unsigned 0xFD×5 → 0x04F1.
- STEP=2, unsigned 200×150 → 0x7530; productDone exactly 5 cycles after start; a start pulse during RUN is ignored.
- EARLY_EXIT=1, STEP=1, multiplier=3, multiplicand=7, multiplier_t=1 → product=21 after 3 cycles; productDone_t=busy_t=1; product_t=1. Same with only multiplicand_t=1 → productDone_t=0, product_t=1.
- Taint: start_t=1 for one IDLE cycle with start=0 → product_t becomes 1 and stays 1 until the next untainted completion clears it to 0.
- Reset: rst low for one cycle mid-RUN → busy, productDone, product, and all taints go to 0 immediately. No productDone follows; a fresh 6×7 then yields 42.
